axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write control registers to a bus master (PS GP port or AXI4-Lite master BFM).
Each register is exported to fabric logic together with a one-cycle write strobe.
This is the register front end for PMOD peripheral controllers; it answers the write/read bursts the master side issues.
It handles independent AW/W arrival, honours WSTRB, holds responses under backpressure, and returns SLVERR for unmapped offsets.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, implemented registers; must be at least 1 and at most 2^(C_S_AXI_ADDR_WIDTH-2).
RESET_VALUE, 32'h0000_0000, reset value of every register.

Ports:
S_AXI_ACLK  in  1  single clock.
S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  NUM_REGS*32  register contents; reg i occupies bits [32i+31:32i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is written (any strobe).

Behaviour:
- Reset, asynchronous on ARESETN low:
  - all VALID/READY outputs 0; BRESP, RRESP, RDATA 0.
  - registers set to RESET_VALUE; reg_wr_pulse 0; AW/W capture flags cleared.
  - Reset mid-transaction aborts it silently: no B or R is issued and no register is modified.
  - READY outputs go high in the first cycle after ARESETN deasserts.
- Write path:
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - On handshake, the address or data is latched and its held flag set. AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - Commit happens at the clock edge at which both are held, or at which the second one handshakes.
    - Mapped index: bytes where WSTRB=1 are updated, others keep their value; reg_wr_pulse[idx]=1 for exactly the next cycle; BRESP=00.
    - Unmapped index (idx >= NUM_REGS): no update, no pulse; BRESP=10 (SLVERR).
  - BVALID rises in the cycle after commit. Commit clears both held flags.
  - BVALID and BRESP are held stable until BREADY; BVALID clears at the edge where BVALID&&BREADY.
  - No new AW/W is accepted while BVALID is high. Maximum write rate is one per 2 cycles.
  - WSTRB=0000 to a mapped register: OKAY response, no data change, pulse still issued.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake in cycle N, RDATA is captured from the register array at that edge; RVALID=1 in cycle N+1.
    - Mapped index: RRESP=00.
    - Unmapped index: RDATA=0, RRESP=10.
  - RDATA, RRESP and RVALID are held until RREADY; RVALID clears on handshake. Maximum read rate is one per 2 cycles.
- Simultaneous read and write to the same register in the same edge: the read returns the pre-write value.
- Read and write channels are fully independent; no ordering between them.
- Address bits [1:0] are ignored (unaligned accesses are treated as aligned).
- reg_out is driven directly from the register flops, so the new value is visible the cycle after commit, the same cycle as BVALID.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, AXIL_DATA_W=32, AXIL_STRB_W=4.
- One natural sub-module, axi4_lite_wr_capture: the AW/W independent-arrival latch with its held flags, producing a commit strobe plus the latched addr/data/strb.
- The read path and register array stay in the top module.

Test Plan:
1. Write then read each offset, OKAY expected on every B and R:
   - 0x0: write 0x0101FFFF, read back 0x0101FFFF.
   - 0x4: write 0xABCD0001, read back 0xABCD0001.
   - 0x8: write 0xDEAD0011, read back 0xDEAD0011.
   - 0xC: write 0xBEEF0011, read back 0xBEEF0011.
   - reg_wr_pulse[i] high for exactly 1 cycle per write.
2. Byte strobes: reg1 holds 0xABCD0001; write 0x11223344 with WSTRB=0101 -> read 0xAB220044.
3. Channel skew: W (0x12345678 to 0x8) 5 cycles before AW -> AWREADY/WREADY behaviour as specified; BVALID 1 cycle after the AW handshake; read returns 0x12345678. Repeat with AW 3 cycles before W.
4. Backpressure: BREADY and RREADY held low 10 cycles -> BVALID/RVALID and BRESP/RDATA stable throughout; AWREADY, WREADY and ARREADY stay 0; each channel completes once its READY rises.
5. Unmapped offset with NUM_REGS=3, ADDR_WIDTH=4:
   - write 0xFFFFFFFF to 0xC -> BRESP=10, no pulse, reg_out unchanged.
   - read 0xC -> RDATA=0, RRESP=10.
6. Reset mid-operation: drive ARESETN low after AW is accepted but before W -> no BVALID; all regs read back 0x00000000 after reset; the next write to 0x0 completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants, response codes and a byte-strobe merge helper.
package axi_lite_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_t;

    function automatic logic [AXIL_DATA_W-1:0] apply_strb(
        input logic [AXIL_DATA_W-1:0] old_val,
        input logic [AXIL_DATA_W-1:0] new_val,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite five-channel bundle; master drives addresses/data/ready-for-response, slave the rest.
interface axi4_lite_reg_slave_if #(
    parameter int ADDR_W = 4
);
    import axi_lite_pkg::*;

    logic [ADDR_W-1:0]      awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_W-1:0]      araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [AXIL_DATA_W-1:0] rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_wr_capture.sv
// Holds AW and W independently until both are present; commit_o fires at the edge the pair completes.
// Zero-cycle pass-through when both arrive together; no acceptance while a B response is outstanding.
module axi4_lite_wr_capture
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   bvalid_i,
    input  logic [ADDR_W-1:0]      awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [AXIL_DATA_W-1:0] wdata_i,
    input  logic [AXIL_STRB_W-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic                   commit_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [AXIL_DATA_W-1:0] data_o,
    output logic [AXIL_STRB_W-1:0] strb_o
);

    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic [ADDR_W-1:0]      aw_addr_q;
    logic [AXIL_DATA_W-1:0] w_data_q;
    logic [AXIL_STRB_W-1:0] w_strb_q;
    logic                   aw_hs, w_hs;

    assign awready_o = en_i && !aw_held_q && !bvalid_i;
    assign wready_o  = en_i && !w_held_q && !bvalid_i;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    // A channel arriving this cycle is forwarded directly so commit needs no extra cycle.
    assign commit_o = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign addr_o   = aw_held_q ? aw_addr_q : awaddr_i;
    assign data_o   = w_held_q ? w_data_q : wdata_i;
    assign strb_o   = w_held_q ? w_strb_q : wstrb_i;

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs)  w_held_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            if (aw_hs) aw_addr_q <= awaddr_i;
            if (w_hs) begin
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank of NUM_REGS words exported to fabric with per-register write pulses.
// B and R valid one cycle after commit/AR handshake; both held until ready, one access per 2 cycles per channel.
module axi4_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] RESET_VALUE        = 32'h0000_0000
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    axi4_lite_reg_slave_if.slave     s_axi,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    logic                                          rdy_en_q;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   regs_q;
    logic [NUM_REGS-1:0]                           pulse_q;
    logic                                          bvalid_q;
    axil_resp_t                                    bresp_q;
    logic                                          rvalid_q;
    axil_resp_t                                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]                 rdata_q;

    logic                          commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] cap_addr;
    logic [AXIL_DATA_W-1:0]        cap_data;
    logic [AXIL_STRB_W-1:0]        cap_strb;
    logic [IDX_W-1:0]              wr_idx, ar_idx;
    logic [NUM_REGS-1:0]           wr_sel;
    logic                          rd_hit;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;
    logic                          ar_hs;
    logic                          unused_ok;

    axi4_lite_wr_capture #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_capture (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .en_i      (rdy_en_q),
        .bvalid_i  (bvalid_q),
        .awaddr_i  (s_axi.awaddr),
        .awvalid_i (s_axi.awvalid),
        .awready_o (s_axi.awready),
        .wdata_i   (s_axi.wdata),
        .wstrb_i   (s_axi.wstrb),
        .wvalid_i  (s_axi.wvalid),
        .wready_o  (s_axi.wready),
        .commit_o  (commit),
        .addr_o    (cap_addr),
        .data_o    (cap_data),
        .strb_o    (cap_strb)
    );

    assign wr_idx = cap_addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_hs  = s_axi.arvalid && s_axi.arready;

    // Decode by equality against each implemented index; anything unmatched is unmapped.
    always_comb begin
        wr_sel = '0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) wr_sel[i] = 1'b1;
            if (ar_idx == IDX_W'(i)) begin
                rd_hit = 1'b1;
                rd_val = regs_q[i];
            end
        end
    end

    // Keeps all READY outputs low until the first edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rdy_en_q <= 1'b0;
        else                rdy_en_q <= 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q   <= {NUM_REGS{RESET_VALUE}};
            pulse_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            pulse_q <= '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
                pulse_q  <= wr_sel;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_sel[i]) regs_q[i] <= apply_strb(regs_q[i], cap_data, cap_strb);
                end
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read samples regs_q before any same-edge write lands.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_val;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = rdy_en_q && !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign reg_out       = regs_q;
    assign reg_wr_pulse  = pulse_q;

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], cap_addr[1:0]};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench: a 4-register and a 3-register instance share one stimulus stream.
module tb_axi4_lite_reg_slave;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [31:0] wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [127:0] reg_out4;
    logic [95:0]  reg_out3;
    logic [3:0]   pulse4;
    logic [2:0]   pulse3;

    int n_checks = 0;
    int n_errors = 0;
    int ptot4 = 0;
    int ptot3 = 0;
    int pc4[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    axi4_lite_reg_slave_if #(.ADDR_W(4)) bus4 ();
    axi4_lite_reg_slave_if #(.ADDR_W(4)) bus3 ();

    assign bus4.awaddr = awaddr;  assign bus3.awaddr = awaddr;
    assign bus4.awprot = 3'b000;  assign bus3.awprot = 3'b000;
    assign bus4.awvalid = awvalid; assign bus3.awvalid = awvalid;
    assign bus4.wdata = wdata;    assign bus3.wdata = wdata;
    assign bus4.wstrb = wstrb;    assign bus3.wstrb = wstrb;
    assign bus4.wvalid = wvalid;  assign bus3.wvalid = wvalid;
    assign bus4.bready = bready;  assign bus3.bready = bready;
    assign bus4.araddr = araddr;  assign bus3.araddr = araddr;
    assign bus4.arprot = 3'b000;  assign bus3.arprot = 3'b000;
    assign bus4.arvalid = arvalid; assign bus3.arvalid = arvalid;
    assign bus4.rready = rready;  assign bus3.rready = rready;

    axi4_lite_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32), .C_S_AXI_ADDR_WIDTH (4),
        .NUM_REGS (4), .RESET_VALUE (32'h0000_0000)
    ) dut4 (
        .S_AXI_ACLK (clk), .S_AXI_ARESETN (rst_n), .s_axi (bus4),
        .reg_out (reg_out4), .reg_wr_pulse (pulse4)
    );

    axi4_lite_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32), .C_S_AXI_ADDR_WIDTH (4),
        .NUM_REGS (3), .RESET_VALUE (32'h0000_0000)
    ) dut3 (
        .S_AXI_ACLK (clk), .S_AXI_ARESETN (rst_n), .s_axi (bus3),
        .reg_out (reg_out3), .reg_wr_pulse (pulse3)
    );

    always @(negedge clk) begin
        ptot4 <= ptot4 + $countones(pulse4);
        ptot3 <= ptot3 + $countones(pulse3);
        for (int i = 0; i < 4; i++) if (pulse4[i]) pc4[i] <= pc4[i] + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] r4, output logic [1:0] r3);
        bit aw_done, w_done, aw_fire, w_fire, rdy_ok;
        int t, bw;
        aw_done = 0; w_done = 0; rdy_ok = 1; t = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 50) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            if (bus4.awready === aw_done) rdy_ok = 0;
            if (bus4.wready === w_done) rdy_ok = 0;
            aw_fire = awvalid && bus4.awready;
            w_fire  = wvalid && bus4.wready;
            @(posedge clk); #1;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            t++;
        end
        awvalid = 0; wvalid = 0;
        check({tag, "_accept"}, aw_done && w_done, 1);
        check({tag, "_ready"}, rdy_ok, 1);
        bready = 1; bw = 0;
        while (!bus4.bvalid && bw < 20) begin
            @(posedge clk); #1; bw++;
        end
        check({tag, "_blat"}, bw, 0);
        r4 = bus4.bresp; r3 = bus3.bresp;
        @(posedge clk); #1;
        bready = 0;
        check({tag, "_bclr"}, bus4.bvalid, 0);
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr,
                           output logic [31:0] d4, output logic [1:0] r4,
                           output logic [31:0] d3, output logic [1:0] r3);
        bit fire;
        int t;
        araddr = addr; arvalid = 1; fire = 0; t = 0;
        while (!fire && t < 20) begin
            fire = bus4.arready;
            @(posedge clk); #1; t++;
        end
        arvalid = 0;
        check({tag, "_ar"}, fire, 1);
        check({tag, "_rlat"}, bus4.rvalid, 1);
        d4 = bus4.rdata; r4 = bus4.rresp; d3 = bus3.rdata; r3 = bus3.rresp;
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check({tag, "_rclr"}, bus4.rvalid, 0);
    endtask

    logic [3:0]  t1_addr [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    logic [31:0] t1_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r4, r3;
        logic [31:0] d4, d3;
        int p0, tot0, tot3_0;
        bit ok;

        rst_n = 0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {bus4.awready, bus4.wready, bus4.arready}, 3'b000);
        check("rst_valid", {bus4.bvalid, bus4.rvalid}, 2'b00);
        check("rst_resp_data", {bus4.bresp, bus4.rresp, bus4.rdata}, 0);
        check("rst_regs", reg_out4, 128'h0);
        check("rst_pulse", pulse4, 4'h0);
        rst_n = 1;
        @(posedge clk); #1;
        check("ready_after_rst", {bus4.awready, bus4.wready, bus4.arready}, 3'b111);

        for (int i = 0; i < 4; i++) begin
            p0 = pc4[i]; tot0 = ptot4;
            do_write("t1w", t1_addr[i], t1_data[i], 4'hF, 0, 0, r4, r3);
            check("t1_bresp", r4, RESP_OKAY);
            check("t1_pulse_idx", pc4[i] - p0, 1);
            check("t1_pulse_tot", ptot4 - tot0, 1);
            do_read("t1r", t1_addr[i], d4, r4, d3, r3);
            check("t1_rdata", d4, t1_data[i]);
            check("t1_rresp", r4, RESP_OKAY);
        end

        p0 = pc4[0];
        do_write("zstrb", 4'h0, 32'hFFFFFFFF, 4'h0, 0, 0, r4, r3);
        check("zstrb_bresp", r4, RESP_OKAY);
        check("zstrb_pulse", pc4[0] - p0, 1);
        do_read("zstrb_r", 4'h0, d4, r4, d3, r3);
        check("zstrb_rdata", d4, 32'h0101FFFF);

        do_write("t2w", 4'h4, 32'h11223344, 4'b0101, 0, 0, r4, r3);
        do_read("t2r", 4'h4, d4, r4, d3, r3);
        check("t2_rdata", d4, 32'hAB220044);

        do_write("t3a", 4'h8, 32'h12345678, 4'hF, 5, 0, r4, r3);
        check("t3a_bresp", r4, RESP_OKAY);
        do_read("t3a_r", 4'h8, d4, r4, d3, r3);
        check("t3a_rdata", d4, 32'h12345678);
        do_write("t3b", 4'h8, 32'hCAFEF00D, 4'hF, 0, 3, r4, r3);
        do_read("t3b_r", 4'h8, d4, r4, d3, r3);
        check("t3b_rdata", d4, 32'hCAFEF00D);

        // Write and read of the same register launched on the same edge, then both stalled.
        awaddr = 4'h8; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("t4_bvalid", bus4.bvalid, 1);
        check("t4_rvalid", bus4.rvalid, 1);
        check("t4_reg_out", reg_out4[95:64], 32'h55AA55AA);
        ok = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus4.bvalid !== 1'b1 || bus4.rvalid !== 1'b1) ok = 0;
            if (bus4.bresp !== 2'b00 || bus4.rdata !== 32'hCAFEF00D) ok = 0;
            if (bus4.awready !== 1'b0 || bus4.wready !== 1'b0 || bus4.arready !== 1'b0) ok = 0;
        end
        check("t4_hold", ok, 1);
        check("t4_rdata_prewrite", bus4.rdata, 32'hCAFEF00D);
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        check("t4_done", {bus4.bvalid, bus4.rvalid}, 2'b00);
        check("t4_ready_back", {bus4.awready, bus4.wready, bus4.arready}, 3'b111);
        do_read("t4r", 4'h8, d4, r4, d3, r3);
        check("t4_rdata_new", d4, 32'h55AA55AA);

        tot3_0 = ptot3;
        do_write("t5w", 4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, r4, r3);
        check("t5_bresp3", r3, RESP_SLVERR);
        check("t5_bresp4", r4, RESP_OKAY);
        check("t5_pulse3", ptot3 - tot3_0, 0);
        check("t5_regs3", reg_out3, {32'h55AA55AA, 32'hAB220044, 32'h0101FFFF});
        do_read("t5r", 4'hC, d4, r4, d3, r3);
        check("t5_rdata3", d3, 32'h0);
        check("t5_rresp3", r3, RESP_SLVERR);
        check("t5_rdata4", d4, 32'hFFFFFFFF);
        do_read("unalign", 4'h6, d4, r4, d3, r3);
        check("unalign_rdata", d4, 32'hAB220044);

        awaddr = 4'h4; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        check("t6_aw_taken", bus4.awready, 0);
        rst_n = 0;
        #1;
        check("t6_rst_ready", {bus4.awready, bus4.wready, bus4.arready}, 3'b000);
        check("t6_rst_regs", reg_out4, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("t6_ready", {bus4.awready, bus4.wready, bus4.arready}, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_b", bus4.bvalid, 0);
        for (int i = 0; i < 4; i++) begin
            do_read("t6r", t1_addr[i], d4, r4, d3, r3);
            check("t6_zero", d4, 32'h0);
        end
        do_write("t6w", 4'h0, 32'h600DF00D, 4'hF, 0, 0, r4, r3);
        check("t6_bresp", r4, RESP_OKAY);
        do_read("t6r2", 4'h0, d4, r4, d3, r3);
        check("t6_rdata", d4, 32'h600DF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
